// File: rtl/led_pattern_ctrl.sv
// led_pattern_ctrl: two debounced push-buttons select and freeze one of four 8-bit LED patterns
// stepped by a divided tick (blink, bouncing scan, binary count, fill).
module led_pattern_ctrl #(
   parameter logic [26:0] TICK_DIV  = 27'd12499999,
   parameter logic [21:0] DB_CYCLES = 22'd2500000
) (
   input  logic       clk,
   input  logic       rst_n,
   input  logic       btn_mode,
   input  logic       btn_pause,
   output logic [7:0] led,
   output logic [1:0] mode,
   output logic       paused
);
   // Button vectors are indexed [0] = mode, [1] = pause.
   logic [1:0]       meta_q, sync_q, db_q, db_d, press;
   logic [1:0][21:0] cnt_q, cnt_d;
   logic [26:0]      tick_cnt_q, tick_cnt_d;
   logic [7:0]       led_q, led_d, step;
   logic [1:0]       mode_q, mode_d;
   logic             paused_q, paused_d, dir_up_q, dir_up_d, tick, end_hit;

   always_comb begin
      db_d  = db_q;
      cnt_d = '0;
      for (int b = 0; b < 2; b++)
         if (sync_q[b] != db_q[b]) begin
            if (cnt_q[b] == DB_CYCLES - 22'd1) db_d[b] = sync_q[b];
            else cnt_d[b] = cnt_q[b] + 22'd1;
         end
      press = db_d & ~db_q;
   end

   // A mode press reloads the pattern and restarts the tick period, discarding any coincident tick.
   always_comb begin
      tick       = ~paused_q & (tick_cnt_q == TICK_DIV);
      end_hit    = dir_up_q ? led_q[7] : led_q[0];
      step       = mode_q == 2'd0 ? ~led_q
                 : mode_q == 2'd1 ? ((dir_up_q ^ end_hit) ? {led_q[6:0], 1'b0} : {1'b0, led_q[7:1]})
                 : mode_q == 2'd2 ? led_q + 8'd1
                 : &led_q ? 8'h00 : {led_q[6:0], 1'b1};
      mode_d     = mode_q + {1'b0, press[0]};
      led_d      = press[0] ? {7'd0, mode_d == 2'd1} : tick ? step : led_q;
      dir_up_d   = press[0] | (dir_up_q ^ (tick & (mode_q == 2'd1) & end_hit));
      tick_cnt_d = (press[0] | tick) ? '0 : paused_q ? tick_cnt_q : tick_cnt_q + 27'd1;
      paused_d   = paused_q ^ press[1];
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         meta_q     <= '0;
         sync_q     <= '0;
         db_q       <= '0;
         cnt_q      <= '0;
         tick_cnt_q <= '0;
         led_q      <= '0;
         mode_q     <= '0;
         paused_q   <= 1'b0;
         dir_up_q   <= 1'b1;
      end else begin
         meta_q     <= {btn_pause, btn_mode};
         sync_q     <= meta_q;
         db_q       <= db_d;
         cnt_q      <= cnt_d;
         tick_cnt_q <= tick_cnt_d;
         led_q      <= led_d;
         mode_q     <= mode_d;
         paused_q   <= paused_d;
         dir_up_q   <= dir_up_d;
      end
   end

   assign led    = led_q;
   assign mode   = mode_q;
   assign paused = paused_q;
endmodule

// File: tb/tb_led_pattern_ctrl.sv
// tb_led_pattern_ctrl: scenario tasks plus randomized button traffic, checked against a
// behavioural model of buttons, tick period and patterns.
module tb_led_pattern_ctrl;
   localparam int TD = 9;
   localparam int DB = 4;
   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          btn_mode = 1'b0;
   logic          btn_pause = 1'b0;
   logic [7:0]    led;
   logic [1:0]    mode;
   logic          paused;
   int            n_checks = 0;
   int            n_fail = 0;
   logic [DB+1:0] hm, hp;
   logic          mdb_m, mdb_p, m_paused;
   logic [1:0]    m_mode;
   logic [7:0]    m_led;
   int            m_phase, m_scan_k;
   int            m_ticks = 0;

   led_pattern_ctrl #(.TICK_DIV(27'd9), .DB_CYCLES(22'd4)) dut (
      .clk(clk), .rst_n(rst_n), .btn_mode(btn_mode), .btn_pause(btn_pause),
      .led(led), .mode(mode), .paused(paused)
   );

   always #5 clk = ~clk;

   initial begin
      #1000000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1);
   end

   function automatic int tri_pos(input int k);
      int r = k % 14;
      return r <= 7 ? r : 14 - r;
   endfunction

   task automatic model_reset();
      hm = '0; hp = '0; mdb_m = 1'b0; mdb_p = 1'b0;
      m_mode = 2'd0; m_led = 8'h00; m_paused = 1'b0; m_phase = 0; m_scan_k = 0;
   endtask

   // A button counts as pressed once its last DB synchronized samples all disagree with the
   // debounced level; samples reach the debouncer two edges after the raw pin.
   task automatic model_step();
      logic pm, pp, tk;
      hm = {hm[DB:0], btn_mode};
      hp = {hp[DB:0], btn_pause};
      pm = 1'b0; pp = 1'b0;
      if (mdb_m ? (hm[DB+1:2] == '0) : (&hm[DB+1:2])) begin mdb_m = ~mdb_m; pm = mdb_m; end
      if (mdb_p ? (hp[DB+1:2] == '0) : (&hp[DB+1:2])) begin mdb_p = ~mdb_p; pp = mdb_p; end
      tk = !m_paused && m_phase == TD;
      if (pm) begin
         m_mode = m_mode + 2'd1;
         m_led = (m_mode == 2'd1) ? 8'h01 : 8'h00;
         m_scan_k = 0;
         m_phase = 0;
      end else if (tk) begin
         m_phase = 0;
         m_ticks++;
         case (m_mode)
            2'd0: m_led = ~m_led;
            2'd1: begin m_scan_k++; m_led = 8'h01 << tri_pos(m_scan_k); end
            2'd2: m_led = m_led + 8'd1;
            default: m_led = (m_led == 8'hFF) ? 8'h00 : {m_led[6:0], 1'b1};
         endcase
      end else if (!m_paused) m_phase++;
      if (pp) m_paused = ~m_paused;
   endtask

   task automatic cyc(input int n);
      repeat (n) begin
         @(posedge clk);
         model_step();
         #1;
      end
   endtask

   task automatic apply_reset();
      #2 rst_n = 1'b0;
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
   endtask

   task automatic run_ticks(input int n);
      int base = m_ticks;
      int g = 0;
      while (m_ticks - base < n && g < n * 12 + 20) begin cyc(1); g++; end
   endtask

   // Raise a button and wait for the DUT to react; edges = cycles from the raw rise.
   task automatic press(input logic which, output int edges);
      logic [1:0] om = mode;
      logic op = paused;
      if (which) btn_pause = 1'b1; else btn_mode = 1'b1;
      edges = 0;
      while (edges < 40 && (which ? paused === op : mode === om)) begin cyc(1); edges++; end
   endtask

   task automatic test_reset();
      apply_reset();
      n_checks += 3;
      if (led !== 8'h00) begin n_fail++; $display("FAIL reset_led: got %h expected 00", led); end
      if (mode !== 2'd0) begin n_fail++; $display("FAIL reset_mode: got %0d expected 0", mode); end
      if (paused !== 1'b0) begin n_fail++; $display("FAIL reset_paused: got %b expected 0", paused); end
   endtask

   task automatic test_blink();
      logic [7:0] exp;
      apply_reset();
      for (int i = 1; i <= 30; i++) begin
         cyc(1);
         exp = ((i / 10) % 2 == 1) ? 8'hFF : 8'h00;
         n_checks++;
         if (led !== exp || led !== m_led) begin
            n_fail++; $display("FAIL blink_edge%0d: got %h expected %h", i, led, exp);
         end
      end
   endtask

   task automatic test_scan();
      int e;
      logic [7:0] exp;
      press(1'b0, e);
      n_checks++;
      if (e < DB + 2 || e > DB + 4 || mode !== 2'd1 || led !== 8'h01) begin
         n_fail++; $display("FAIL scan_enter: edges %0d mode %0d led %h, expected 6..8 1 01", e, mode, led);
      end
      for (int k = 1; k <= 16; k++) begin
         run_ticks(1);
         exp = 8'h01 << tri_pos(k);
         n_checks++;
         if (led !== exp) begin n_fail++; $display("FAIL scan_tick%0d: got %h expected %h", k, led, exp); end
      end
      btn_mode = 1'b0;
      cyc(DB + 3);
   endtask

   task automatic test_count();
      int e;
      press(1'b0, e);
      btn_mode = 1'b0;
      n_checks++;
      if (mode !== 2'd2 || led !== 8'h00) begin
         n_fail++; $display("FAIL count_enter: mode %0d led %h expected 2 00", mode, led);
      end
      run_ticks(255);
      n_checks++;
      if (led !== 8'hFF) begin n_fail++; $display("FAIL count_255: got %h expected ff", led); end
      run_ticks(1);
      n_checks++;
      if (led !== 8'h00) begin n_fail++; $display("FAIL count_wrap: got %h expected 00", led); end
   endtask

   task automatic test_fill();
      int e;
      logic [8:0] t;
      logic [7:0] exp;
      press(1'b0, e);
      btn_mode = 1'b0;
      n_checks++;
      if (mode !== 2'd3 || led !== 8'h00) begin
         n_fail++; $display("FAIL fill_enter: mode %0d led %h expected 3 00", mode, led);
      end
      for (int k = 1; k <= 9; k++) begin
         run_ticks(1);
         t = (9'd1 << k) - 9'd1;
         exp = (k == 9) ? 8'h00 : t[7:0];
         n_checks++;
         if (led !== exp) begin n_fail++; $display("FAIL fill_tick%0d: got %h expected %h", k, led, exp); end
      end
   endtask

   task automatic test_bounce();
      logic [1:0] m0, prev, exp;
      int changes = 0;
      int at = 0;
      m0 = mode;
      exp = m0 + 2'd1;
      repeat ($urandom_range(3, 6)) begin
         btn_mode = 1'b1; cyc($urandom_range(1, 2));
         btn_mode = 1'b0; cyc($urandom_range(1, 3));
      end
      n_checks++;
      if (mode !== m0) begin n_fail++; $display("FAIL bounce_glitch: mode %0d expected %0d", mode, m0); end
      btn_mode = 1'b1;
      prev = mode;
      for (int i = 1; i <= 20; i++) begin
         cyc(1);
         if (mode !== prev) begin changes++; at = i; prev = mode; end
      end
      btn_mode = 1'b0;
      cyc(DB + 4);
      n_checks += 3;
      if (changes != 1) begin n_fail++; $display("FAIL bounce_count: got %0d increments expected 1", changes); end
      if (at < DB + 2 || at > DB + 4) begin n_fail++; $display("FAIL bounce_window: edge %0d expected 6..8", at); end
      if (mode !== exp || mode !== m_mode) begin n_fail++; $display("FAIL bounce_mode: got %0d expected %0d", mode, exp); end
   endtask

   task automatic test_coincident();
      logic [1:0] om1;
      logic [7:0] exp;
      int g = 0;
      while (m_phase != TD - DB - 1 && g < 20) begin cyc(1); g++; end
      om1 = m_mode + 2'd1;
      exp = (om1 == 2'd1) ? 8'h01 : 8'h00;
      btn_mode = 1'b1;
      cyc(DB + 2);
      n_checks += 2;
      if (mode !== om1) begin n_fail++; $display("FAIL coincident_mode: got %0d expected %0d", mode, om1); end
      if (led !== exp) begin n_fail++; $display("FAIL coincident_led: got %h expected %h", led, exp); end
      btn_mode = 1'b0;
      cyc(DB + 3);
   endtask

   task automatic test_pause();
      int e, diffs, n;
      logic [1:0] om1;
      logic [7:0] frz;
      press(1'b1, e);
      btn_pause = 1'b0;
      n_checks++;
      if (e < DB + 2 || e > DB + 4 || paused !== 1'b1) begin
         n_fail++; $display("FAIL pause_enter: edges %0d paused %b expected 6..8 1", e, paused);
      end
      frz = led; diffs = 0;
      repeat (50) begin cyc(1); if (led !== frz) diffs++; end
      n_checks++;
      if (diffs != 0) begin n_fail++; $display("FAIL pause_frozen: %0d changes expected 0", diffs); end
      om1 = mode + 2'd1;
      press(1'b0, e);
      btn_mode = 1'b0;
      n_checks++;
      if (mode !== om1 || led !== {7'd0, om1 == 2'd1} || paused !== 1'b1) begin
         n_fail++; $display("FAIL pause_mode: mode %0d led %h paused %b expected %0d init 1", mode, led, paused, om1);
      end
      frz = led; diffs = 0;
      repeat (30) begin cyc(1); if (led !== frz) diffs++; end
      n_checks++;
      if (diffs != 0) begin n_fail++; $display("FAIL pause_mode_frozen: %0d changes expected 0", diffs); end
      press(1'b1, e);
      btn_pause = 1'b0;
      n_checks++;
      if (paused !== 1'b0) begin n_fail++; $display("FAIL pause_resume: paused %b expected 0", paused); end
      frz = led; n = 0;
      while (led === frz && n < 30) begin cyc(1); n++; end
      n_checks++;
      if (n != TD + 1 || led !== m_led) begin
         n_fail++; $display("FAIL pause_first_tick: after %0d edges led %h, expected 10 edges led %h", n, led, m_led);
      end
   endtask

   task automatic test_random();
      int rm = 0;
      int rp = 0;
      for (int i = 0; i < 1500; i++) begin
         if (rm == 0) begin btn_mode = 1'($urandom_range(0, 1)); rm = $urandom_range(1, 10); end
         if (rp == 0) begin btn_pause = 1'($urandom_range(0, 1)); rp = $urandom_range(1, 12); end
         rm--; rp--;
         cyc(1);
         n_checks += 3;
         if (led !== m_led) begin n_fail++; $display("FAIL random_led@%0d: got %h expected %h", i, led, m_led); end
         if (mode !== m_mode) begin n_fail++; $display("FAIL random_mode@%0d: got %0d expected %0d", i, mode, m_mode); end
         if (paused !== m_paused) begin n_fail++; $display("FAIL random_paused@%0d: got %b expected %b", i, paused, m_paused); end
      end
      btn_mode = 1'b0; btn_pause = 1'b0;
      cyc(DB + 3);
   endtask

   task automatic test_async_reset();
      int e, g, rises;
      logic prev;
      apply_reset();
      press(1'b0, e); btn_mode = 1'b0; cyc(DB + 3);
      press(1'b0, e); btn_mode = 1'b0;
      g = 0;
      while (m_led != 8'h37 && g < 1000) begin cyc(1); g++; end
      btn_pause = 1'b1;
      g = 0;
      while (paused !== 1'b1 && g < 20) begin cyc(1); g++; end
      n_checks++;
      if (led !== 8'h37 || mode !== 2'd2 || paused !== 1'b1) begin
         n_fail++; $display("FAIL areset_setup: led %h mode %0d paused %b expected 37 2 1", led, mode, paused);
      end
      #2 rst_n = 1'b0;
      model_reset();
      #1;
      n_checks += 3;
      if (led !== 8'h00) begin n_fail++; $display("FAIL areset_led: got %h expected 00", led); end
      if (mode !== 2'd0) begin n_fail++; $display("FAIL areset_mode: got %0d expected 0", mode); end
      if (paused !== 1'b0) begin n_fail++; $display("FAIL areset_paused: got %b expected 0", paused); end
      repeat (2) @(posedge clk);
      #1 rst_n = 1'b1;
      rises = 0; prev = paused;
      repeat (20) begin cyc(1); if (paused && !prev) rises++; prev = paused; end
      btn_pause = 1'b0;
      cyc(DB + 5);
      n_checks += 2;
      if (rises != 1) begin n_fail++; $display("FAIL held_press_count: got %0d pulses expected 1", rises); end
      if (paused !== 1'b1 || paused !== m_paused) begin n_fail++; $display("FAIL held_press_state: paused %b expected 1", paused); end
   endtask

   initial begin
      test_reset();
      test_blink();
      test_scan();
      test_count();
      test_fill();
      test_bounce();
      test_coincident();
      test_pause();
      test_random();
      test_async_reset();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end
endmodule
